// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector with overlap control and a
// saturating match counter; match_o is a registered Moore output.
module seq_detector_param #(
  parameter  int unsigned MAX_LEN = 8,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_load_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic               cnt_clr_i,
  input  logic               valid_i,
  input  logic               next_i,
  output logic               match_o,
  output logic [CNT_W-1:0]   match_cnt_o,
  output logic               armed_o,
  output logic               cfg_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HUNT  = 2'd1,
    S_MATCH = 2'd2
  } state_t;

  state_t             state_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill_q;
  logic               ovl_q;

  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_nxt;
  logic               cfg_ok;
  logic               accept;
  logic               hit;

  // Shift/fill look-ahead and hit detection on the post-shift history
  always_comb begin
    cfg_ok   = (cfg_len_i != '0) && (cfg_len_i <= LEN_W'(MAX_LEN));
    accept   = armed_o && valid_i && !cfg_load_i;
    hist_nxt = {hist_q[MAX_LEN-2:0], next_i};
    fill_nxt = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    hit = accept && (fill_nxt >= len_q) && (((hist_nxt ^ pat_q) & len_mask) == '0);
  end

  // FSM, history, configuration and counter registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      hist_q      <= '0;
      pat_q       <= '0;
      len_q       <= '0;
      fill_q      <= '0;
      ovl_q       <= 1'b0;
      match_o     <= 1'b0;
      match_cnt_o <= '0;
      armed_o     <= 1'b0;
      cfg_err_o   <= 1'b0;
    end else begin
      cfg_err_o <= 1'b0;
      if (cfg_load_i) begin
        hist_q  <= '0;
        fill_q  <= '0;
        match_o <= 1'b0;
        if (cfg_ok) begin
          pat_q   <= cfg_pattern_i;
          len_q   <= cfg_len_i;
          ovl_q   <= cfg_overlap_i;
          state_q <= S_HUNT;
          armed_o <= 1'b1;
        end else begin
          state_q   <= S_IDLE;
          armed_o   <= 1'b0;
          cfg_err_o <= 1'b1;
        end
      end else if (accept) begin
        hist_q  <= hist_nxt;
        // Non-overlap mode forces a full fresh pattern after each hit
        fill_q  <= (hit && !ovl_q) ? '0 : fill_nxt;
        state_q <= hit ? S_MATCH : S_HUNT;
        match_o <= hit;
      end else if (state_q == S_MATCH) begin
        state_q <= S_HUNT;
        match_o <= 1'b0;
      end

      if (cnt_clr_i) begin
        match_cnt_o <= '0;
      end else if (hit && (match_cnt_o != '1)) begin
        match_cnt_o <= match_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule
